// File: rtl/udp_rx_pix_unpack_if.sv
// Bundle between the UDP receiver payload side and the rebuilt raster pixel stream.
// The master drives the receiver words; the slave (the unpacker) drives the pixel side.
interface udp_rx_pix_unpack_if;
  logic        rec_vs;
  logic        rec_en;
  logic [31:0] rec_data;
  logic        rec_pkt_done;
  logic        pix_vld;
  logic [15:0] pix_rgb565;
  logic [23:0] pix_rgb888;
  logic [10:0] pix_col;
  logic [10:0] pix_row;
  logic        frame_start;
  logic        line_end;
  logic        frame_end;
  logic        short_err;
  logic        ovf_err;

  modport master (
    output rec_vs, rec_en, rec_data, rec_pkt_done,
    input  pix_vld, pix_rgb565, pix_rgb888, pix_col, pix_row,
    input  frame_start, line_end, frame_end, short_err, ovf_err
  );

  modport slave (
    input  rec_vs, rec_en, rec_data, rec_pkt_done,
    output pix_vld, pix_rgb565, pix_rgb888, pix_col, pix_row,
    output frame_start, line_end, frame_end, short_err, ovf_err
  );
endinterface

// File: rtl/udp_rx_pix_unpack.sv
// Rebuilds a raster RGB565 pixel stream (two pixels per 32-bit UDP payload word) with
// column/row position, line/frame markers, short-line and overflow flags.
module udp_rx_pix_unpack #(
  parameter int H_PIX      = 480,
  parameter int V_LINES    = 1080,
  parameter int FIFO_DEPTH = 4
) (
  input  logic gmii_rx_clk,
  input  logic rst,
  udp_rx_pix_unpack_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [10:0]   COL_LAST = 11'(H_PIX - 1);
  localparam logic [10:0]   ROW_LAST = 11'(V_LINES - 1);
  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {WAIT_VS, LINE, DRAIN} state_t;
  state_t state_reg, state_next;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [15:0]   lo_pix_reg;
  logic          lo_pending_reg;
  logic [10:0]   col_reg, row_reg;

  logic          pix_vld_reg, frame_start_reg, line_end_reg, frame_end_reg;
  logic          short_err_reg, ovf_err_reg;
  logic [15:0]   rgb_reg;
  logic [10:0]   pix_col_reg, pix_row_reg;

  logic          active, pop, emit, emit_ok, push, drop, last_pix, flush, short_line;
  logic [15:0]   emit_pix;

  always_comb begin
    state_next = state_reg;
    flush      = 1'b0;
    short_line = 1'b0;
    active     = (state_reg != WAIT_VS);
    // A pending lower half always goes out before the next word is popped.
    pop        = active && !lo_pending_reg && (count_reg != '0);
    emit       = pop || (active && lo_pending_reg);
    emit_ok    = emit && !bus.rec_vs;
    emit_pix   = lo_pending_reg ? lo_pix_reg : mem[rd_ptr_reg][31:16];
    last_pix   = emit && (col_reg == COL_LAST) && (row_reg == ROW_LAST);
    push       = active && bus.rec_en && ((count_reg != FULL) || pop);
    drop       = active && bus.rec_en && (count_reg == FULL) && !pop;

    if (bus.rec_vs) begin
      state_next = LINE;
      flush      = 1'b1;
    end else if (last_pix) begin
      state_next = WAIT_VS;
      flush      = 1'b1;
    end else begin
      case (state_reg)
        LINE:  if (bus.rec_pkt_done) state_next = DRAIN;
        DRAIN: begin
          if ((count_reg == '0) && !lo_pending_reg) begin
            state_next = LINE;
            if (col_reg != '0) begin
              short_line = 1'b1;
              // A short final line ends the frame without a frame_end marker.
              if (row_reg == ROW_LAST) begin
                state_next = WAIT_VS;
                flush      = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (push && !flush) mem[wr_ptr_reg] <= bus.rec_data;
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (rst) state_reg <= WAIT_VS;
    else     state_reg <= state_next;
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      lo_pix_reg      <= '0;
      lo_pending_reg  <= 1'b0;
      col_reg         <= '0;
      row_reg         <= '0;
      pix_vld_reg     <= 1'b0;
      frame_start_reg <= 1'b0;
      line_end_reg    <= 1'b0;
      frame_end_reg   <= 1'b0;
      short_err_reg   <= 1'b0;
      ovf_err_reg     <= 1'b0;
      rgb_reg         <= '0;
      pix_col_reg     <= '0;
      pix_row_reg     <= '0;
    end else begin
      pix_vld_reg     <= emit_ok;
      frame_start_reg <= emit_ok && (col_reg == '0) && (row_reg == '0);
      line_end_reg    <= emit_ok && (col_reg == COL_LAST);
      frame_end_reg   <= emit_ok && last_pix;
      short_err_reg   <= short_line;
      if (emit_ok) begin
        rgb_reg     <= emit_pix;
        pix_col_reg <= col_reg;
        pix_row_reg <= row_reg;
      end

      if (flush) begin
        wr_ptr_reg     <= '0;
        rd_ptr_reg     <= '0;
        count_reg      <= '0;
        lo_pending_reg <= 1'b0;
        col_reg        <= '0;
        row_reg        <= '0;
      end else begin
        wr_ptr_reg <= wr_ptr_reg + AW'(push);
        rd_ptr_reg <= rd_ptr_reg + AW'(pop);
        count_reg  <= count_reg + CW'(push) - CW'(pop);
        if (pop) begin
          lo_pix_reg     <= mem[rd_ptr_reg][15:0];
          lo_pending_reg <= 1'b1;
        end else if (emit) begin
          lo_pending_reg <= 1'b0;
        end
        if (emit) begin
          if (col_reg == COL_LAST) begin
            col_reg <= '0;
            row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 11'd1;
          end else begin
            col_reg <= col_reg + 11'd1;
          end
        end else if (short_line) begin
          col_reg <= '0;
          row_reg <= row_reg + 11'd1;
        end
      end

      if (bus.rec_vs)          ovf_err_reg <= 1'b0;
      else if (drop && !flush) ovf_err_reg <= 1'b1;
    end
  end

  assign bus.pix_vld     = pix_vld_reg;
  assign bus.pix_rgb565  = rgb_reg;
  assign bus.pix_rgb888  = {rgb_reg[15:11], 3'b000, rgb_reg[10:5], 2'b00, rgb_reg[4:0], 3'b000};
  assign bus.pix_col     = pix_col_reg;
  assign bus.pix_row     = pix_row_reg;
  assign bus.frame_start = frame_start_reg;
  assign bus.line_end    = line_end_reg;
  assign bus.frame_end   = frame_end_reg;
  assign bus.short_err   = short_err_reg;
  assign bus.ovf_err     = ovf_err_reg;
endmodule
